// File: rtl/x_injector.sv
// Controlled X/Z fault injector: passes bus_in to bus_out and, in
// pseudo-random bursts, overrides selected bits with 1'bx / 1'bz.
// Behavioural verification utility; the X/Z drive is intentional.
module x_injector #(
  parameter int          BUS_WIDTH      = 32,
  parameter bit          INJECT_X       = 1'b1,
  parameter bit          INJECT_Z       = 1'b1,
  parameter logic [31:0] LFSR_SEED      = 32'hACE12357,
  parameter int          HOLDOFF_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [7:0]           inj_rate,
  input  logic [3:0]           burst_len,
  input  logic [BUS_WIDTH-1:0] bus_in,
  output wire  [BUS_WIDTH-1:0] bus_out,
  output logic                 inject_active,
  output logic [31:0]          inject_count
);

  localparam logic [31:0] SEED    = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] TAPS    = 32'h80200003;
  localparam bit          CAN_INJ = INJECT_X | INJECT_Z;
  localparam int          IDX_W   = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_INJECT, S_HOLDOFF} state_t;

  state_t               r_state, w_state_nxt;
  logic [31:0]          r_lfsr, w_lfsr_nxt;
  logic [3:0]           r_burst_cnt, w_burst_nxt;
  logic [31:0]          r_hold_cnt, w_hold_nxt;
  logic [BUS_WIDTH-1:0] r_mask, r_kind, w_mask, w_kind, w_corrupt;
  logic [IDX_W-1:0]     w_fix_idx;
  logic                 r_active;
  logic [31:0]          r_count;

  // Galois step: shift right, fold taps in when a one falls out
  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

  // Candidate mask/kind drawn from the current LFSR; mask never empty
  assign w_fix_idx = IDX_W'(32'(r_lfsr[4:0]) % 32'(BUS_WIDTH));
  always_comb begin
    w_mask = '0;
    w_kind = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      w_mask[i] = r_lfsr[i % 32] & r_lfsr[(i + 16) % 32];
      w_kind[i] = (INJECT_X && INJECT_Z) ? r_lfsr[(i + 8) % 32] : INJECT_Z;
    end
    if (w_mask == '0) w_mask[w_fix_idx] = 1'b1;
  end

  // Next-state: enable low forces IDLE from anywhere
  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst_cnt;
    w_hold_nxt  = r_hold_cnt;
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CAN_INJ && (inj_rate == 8'hFF || r_lfsr[7:0] < inj_rate)) begin
            w_state_nxt = S_INJECT;
            w_burst_nxt = (burst_len == 4'd0) ? 4'd1 : burst_len;
          end
        end
        S_INJECT: begin
          if (r_burst_cnt <= 4'd1) begin
            if (HOLDOFF_CYCLES == 0) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_HOLDOFF;
              w_hold_nxt  = 32'(HOLDOFF_CYCLES);
            end
          end else begin
            w_burst_nxt = r_burst_cnt - 4'd1;
          end
        end
        S_HOLDOFF: begin
          if (r_hold_cnt <= 32'd1) w_state_nxt = S_IDLE;
          else                     w_hold_nxt  = r_hold_cnt - 32'd1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, LFSR, corruption pattern and saturating activity counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED;
      r_burst_cnt <= '0;
      r_hold_cnt  <= '0;
      r_mask      <= '0;
      r_kind      <= '0;
      r_active    <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_hold_cnt  <= w_hold_nxt;
      if (w_state_nxt == S_INJECT) begin
        r_mask <= w_mask;
        r_kind <= w_kind;
      end
      r_active <= (w_state_nxt == S_INJECT);
      if (r_active && r_count != 32'hFFFFFFFF) r_count <= r_count + 32'd1;
    end
  end

  // rst gates corruption immediately so the bus is clean throughout reset
  assign w_corrupt = {BUS_WIDTH{r_active & ~rst}} & r_mask;

  for (genvar g = 0; g < BUS_WIDTH; g++) begin : g_bit
    assign bus_out[g] = w_corrupt[g] ? (r_kind[g] ? 1'bz : 1'bx) : bus_in[g];
  end

  assign inject_active = r_active;
  assign inject_count  = r_count;

endmodule
